// File: rtl/viterbi_frame_ctrl.sv
// Frame-level sequencer for the Viterbi decoder datapath.
// Accepts one frame of symbols, drives branch-metric/ACS and survivor-memory
// write strobes per accepted symbol, then runs a descending traceback.
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sym_valid,
    output logic              sym_ready,
    output logic              pm_init,
    output logic              en_bm,
    output logic              en_acs,
    output logic              sm_we,
    output logic [ADDR_W-1:0] sm_waddr,
    output logic              tb_load,
    output logic              tb_en,
    output logic [ADDR_W-1:0] sm_raddr,
    output logic              bit_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ACS,
        DRAIN,
        TB_LOAD,
        TRACE,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] wcnt;
    logic              wcnt_last;
    logic              raddr_zero;

    assign wcnt_last  = (wcnt == LAST_ADDR);
    assign raddr_zero = (sm_raddr == '0);
    assign en_bm      = sym_ready & sym_valid;

    // State register; reset returns to IDLE from anywhere, even mid-frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded strobes; sym_ready depends on state only.
    always_comb begin
        state_next = state;
        sym_ready  = 1'b0;
        pm_init    = 1'b0;
        tb_load    = 1'b0;
        tb_en      = 1'b0;
        bit_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                pm_init    = 1'b1;
                state_next = ACS;
            end
            ACS: begin
                sym_ready = 1'b1;
                if (sym_valid && wcnt_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = TB_LOAD;
            end
            TB_LOAD: begin
                tb_load    = 1'b1;
                state_next = TRACE;
            end
            TRACE: begin
                tb_en     = 1'b1;
                bit_valid = 1'b1;
                if (raddr_zero) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write counter: cleared per frame, advances only on an accepted symbol.
    // It saturates on the last index so it never wraps at FRAME_LEN=2^ADDR_W.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt <= '0;
        end else if (state == INIT) begin
            wcnt <= '0;
        end else if (en_bm && !wcnt_last) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    // One-stage pipeline: symbol i is written to survivor address i one
    // cycle after acceptance; the address holds between writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_acs   <= 1'b0;
            sm_we    <= 1'b0;
            sm_waddr <= '0;
        end else begin
            en_acs <= en_bm;
            sm_we  <= en_bm;
            if (en_bm) begin
                sm_waddr <= wcnt;
            end
        end
    end

    // Traceback read address: preset to the last index while draining,
    // then counts down once per TRACE cycle and stops at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sm_raddr <= '0;
        end else begin
            case (state)
                INIT:    sm_raddr <= '0;
                DRAIN:   sm_raddr <= LAST_ADDR;
                TRACE: begin
                    if (!raddr_zero) begin
                        sm_raddr <= sm_raddr - 1'b1;
                    end
                end
                default: sm_raddr <= sm_raddr;
            endcase
        end
    end

endmodule
